axi4_lite_regfile_slave: RTL and testbench
==========================================

AXI4_LITE_REGFILE_SLAVE -- requirements
Module: axi4_lite_regfile_slave

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter REG_DATA_WIDTH, default 32, data width; fixed at 32, so there are 4 strobe bits.
REQ-003 SHALL have parameter NUM_REGS, default 8, register count; a power of 2, at least 2.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: axi4_lite_aclk input 1, clock; axi4_lite_aresetn input 1, reset.
REQ-005 SHALL have write-address ports: awaddr input ADDRESS_WIDTH; awvalid input 1; awready output 1.
REQ-006 SHALL have write-data ports: wdata input 32; wstrb input 4, byte enables; wvalid input 1; wready output 1.
REQ-007 SHALL have write-response ports: bresp output 2; bvalid output 1; bready input 1.
REQ-008 SHALL have read-address ports: araddr input ADDRESS_WIDTH; arvalid input 1; arready output 1.
REQ-009 SHALL have read-data ports: rdata output 32; rresp output 2; rvalid output 1; rready input 1.

Function
REQ-010 SHALL decode word index = addr[2 +: log2(NUM_REGS)]; an address is valid iff addr[1:0]==0 and addr < NUM_REGS*4.
REQ-011 SHALL run independent write and read channels; both may complete in the same cycle.
REQ-012 SHALL drive awready high when no AW is latched and bvalid=0; AW handshake (awvalid&&awready) latches awaddr.
REQ-013 SHALL drive wready high when no W is latched and bvalid=0; W handshake latches wdata and wstrb.
REQ-014 SHALL accept AW and W in either order or the same cycle; commit occurs on the edge after both are latched, or on the handshake edge itself if both arrive together.
REQ-015 SHALL, on commit with a valid address, update byte k of the register only where wstrb[k]=1; bresp=2'b00 (OKAY).
REQ-016 SHALL, on commit with an invalid address, leave all registers unchanged; bresp=2'b10 (SLVERR).
REQ-017 SHALL assert bvalid on the cycle after commit; both AW and W in cycle N gives bvalid in N+1.
REQ-018 SHALL hold bvalid and bresp stable until bvalid&&bready, then clear bvalid and the latched AW/W flags; readies reassert the next cycle.
REQ-019 SHALL implement read FSM states R_IDLE and R_RESP; arready=1 only in R_IDLE.
REQ-020 SHALL, on AR handshake in R_IDLE, register rdata and rresp and go to R_RESP; rvalid=1 in R_RESP, so arvalid at N gives rvalid at N+1.
REQ-021 SHALL return register contents with rresp=2'b00 for a valid read address, and rdata=0 with rresp=2'b10 for an invalid one.
REQ-022 SHALL hold rdata and rresp stable in R_RESP until rvalid&&rready, then return to R_IDLE; back-to-back reads complete every 2 cycles.
REQ-023 SHALL sample rdata for a read and a write commit to the same register on the same edge from the pre-write value.
REQ-024 SHALL accept a new AW or W only after B completes; stalled bready SHALL block further writes.
REQ-025 SHALL keep the read path independent of B stalls, and the write path independent of R stalls.

Reset
REQ-026 SHALL, while axi4_lite_aresetn=0, clear all registers, AW/W latches, bvalid, rvalid, bresp, rresp and rdata to 0, and drive awready, wready and arready to 0.
REQ-027 SHALL raise awready, wready and arready on the first clock edge after reset deasserts, with the read FSM in R_IDLE.
REQ-028 SHALL abort any in-flight transaction on reset mid-operation, with no register update and no B or R issued.

Verification
REQ-029 The bench SHALL drive AW 0x04 and W 0xDEADBEEF with strb 0xF in the same cycle N -> bvalid at N+1 with bresp 00; a read of 0x04 returns 0xDEADBEEF with rresp 00.
REQ-030 The bench SHALL write 0x11223344 with strb 0xF then 0xAABBCCDD with strb 0x5 to 0x08 -> readback is 0x11BB33DD.
REQ-031 The bench SHALL drive W 3 cycles before AW to 0x0C, data 0x5 -> wready low after the W handshake, commit after AW, bvalid 1 cycle after AW, readback 0x5.
REQ-032 The bench SHALL write to 0x20 and 0x06 with NUM_REGS=8 -> bresp 10, registers unchanged; a read of 0x20 returns rdata 0 and rresp 10.
REQ-033 The bench SHALL hold bready low for 5 cycles -> bvalid held, awready and wready stay 0, and a concurrent read of 0x04 still completes.
REQ-034 The bench SHALL assert reset while bvalid=1 and rvalid=1 -> all outputs 0 immediately, all registers read 0 after reset.

Source files
------------

// File: rtl/axi4_lite_regfile_slave.sv
// ---------------------------------------------------------------------------
// axi4_lite_regfile_slave
//
// AXI4-Lite slave exposing NUM_REGS 32-bit registers. Writes honour byte
// strobes; out-of-range or misaligned addresses return SLVERR and have no
// effect. The read and write channels run independently of each other.
//
// Ports
//   axi4_lite_aclk     : clock
//   axi4_lite_aresetn  : asynchronous reset, active low
//   aw*                : write address channel (awaddr, awvalid, awready)
//   w*                 : write data channel    (wdata, wstrb, wvalid, wready)
//   b*                 : write response        (bresp, bvalid, bready)
//   ar*                : read address channel  (araddr, arvalid, arready)
//   r*                 : read data channel     (rdata, rresp, rvalid, rready)
// ---------------------------------------------------------------------------
module axi4_lite_regfile_slave #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int REG_DATA_WIDTH = 32,
   parameter int NUM_REGS       = 8
) (
   input  logic                        axi4_lite_aclk,
   input  logic                        axi4_lite_aresetn,

   input  logic [ADDRESS_WIDTH-1:0]    awaddr,
   input  logic                        awvalid,
   output logic                        awready,

   input  logic [REG_DATA_WIDTH-1:0]   wdata,
   input  logic [REG_DATA_WIDTH/8-1:0] wstrb,
   input  logic                        wvalid,
   output logic                        wready,

   output logic [1:0]                  bresp,
   output logic                        bvalid,
   input  logic                        bready,

   input  logic [ADDRESS_WIDTH-1:0]    araddr,
   input  logic                        arvalid,
   output logic                        arready,

   output logic [REG_DATA_WIDTH-1:0]   rdata,
   output logic [1:0]                  rresp,
   output logic                        rvalid,
   input  logic                        rready
);

   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam int STRB_W = REG_DATA_WIDTH / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {R_IDLE, R_RESP} r_state_e;

   // Aligned and inside the register window; upper bits must all be zero.
   function automatic logic addr_valid(input logic [ADDRESS_WIDTH-1:0] a);
      return (a[1:0] == 2'b00) && ((a >> (IDX_W + 2)) == '0);
   endfunction

   // Register file
   logic [REG_DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [REG_DATA_WIDTH-1:0] regs_d [NUM_REGS];

   // Holds the readies low while in reset and releases them on the first edge after it
   logic active_q;

   // Write channel state
   logic                      aw_latched_q, aw_latched_d;
   logic [ADDRESS_WIDTH-1:0]  awaddr_q, awaddr_d;
   logic                      w_latched_q, w_latched_d;
   logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]         wstrb_q, wstrb_d;
   logic                      bvalid_q, bvalid_d;
   logic [1:0]                bresp_q, bresp_d;

   // Read channel state
   r_state_e                  r_state_q, r_state_d;
   logic [REG_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]                rresp_q, rresp_d;

   logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                      commit;
   logic [ADDRESS_WIDTH-1:0]  commit_addr;
   logic [REG_DATA_WIDTH-1:0] commit_data;
   logic [STRB_W-1:0]         commit_strb;
   logic [IDX_W-1:0]          commit_idx;
   logic [IDX_W-1:0]          read_idx;

   // Handshakes and the commit condition. A beat arriving this cycle counts as
   // latched, so AW and W in the same cycle commit on that very edge.
   always_comb begin
      aw_hs       = awvalid && awready;
      w_hs        = wvalid && wready;
      b_hs        = bvalid_q && bready;
      ar_hs       = arvalid && arready;
      r_hs        = rvalid && rready;
      commit_addr = aw_hs ? awaddr : awaddr_q;
      commit_data = w_hs ? wdata : wdata_q;
      commit_strb = w_hs ? wstrb : wstrb_q;
      commit_idx  = commit_addr[2 +: IDX_W];
      read_idx    = araddr[2 +: IDX_W];
      commit      = !bvalid_q && (aw_latched_q || aw_hs) && (w_latched_q || w_hs);
   end

   // Write channel next state: latch beats, commit into the register file,
   // raise the response, and clear everything once the response is taken.
   // Commit and B completion are mutually exclusive since one needs bvalid low
   // and the other bvalid high.
   always_comb begin
      aw_latched_d = aw_latched_q;
      awaddr_d     = awaddr_q;
      w_latched_d  = w_latched_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      regs_d       = regs_q;

      if (aw_hs) begin
         aw_latched_d = 1'b1;
         awaddr_d     = awaddr;
      end
      if (w_hs) begin
         w_latched_d = 1'b1;
         wdata_d     = wdata;
         wstrb_d     = wstrb;
      end
      if (commit) begin
         bvalid_d = 1'b1;
         if (addr_valid(commit_addr)) begin
            bresp_d = RESP_OKAY;
            for (int k = 0; k < STRB_W; k++) begin
               if (commit_strb[k]) begin
                  regs_d[commit_idx][8*k +: 8] = commit_data[8*k +: 8];
               end
            end
         end else begin
            bresp_d = RESP_SLVERR;
         end
      end
      if (b_hs) begin
         bvalid_d     = 1'b0;
         aw_latched_d = 1'b0;
         w_latched_d  = 1'b0;
      end
   end

   // Write channel and register file flops
   always_ff @(posedge axi4_lite_aclk or negedge axi4_lite_aresetn) begin
      if (!axi4_lite_aresetn) begin
         active_q     <= 1'b0;
         aw_latched_q <= 1'b0;
         awaddr_q     <= '0;
         w_latched_q  <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         bvalid_q     <= 1'b0;
         bresp_q      <= 2'b00;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         active_q     <= 1'b1;
         aw_latched_q <= aw_latched_d;
         awaddr_q     <= awaddr_d;
         w_latched_q  <= w_latched_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read FSM state register, with the registered read data alongside it
   always_ff @(posedge axi4_lite_aclk or negedge axi4_lite_aresetn) begin
      if (!axi4_lite_aresetn) begin
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
      end else begin
         r_state_q <= r_state_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Read FSM next state. Data is sampled from regs_q, so a write committing
   // on the same edge is not yet visible to the read.
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_RESP;
               if (addr_valid(araddr)) begin
                  rdata_d = regs_q[read_idx];
                  rresp_d = RESP_OKAY;
               end else begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
               end
            end
         end
         R_RESP: begin
            if (r_hs) begin
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read FSM outputs and write channel readies
   always_comb begin
      arready = active_q && (r_state_q == R_IDLE);
      rvalid  = (r_state_q == R_RESP);
      rdata   = rdata_q;
      rresp   = rresp_q;
      awready = active_q && !aw_latched_q && !bvalid_q;
      wready  = active_q && !w_latched_q && !bvalid_q;
      bvalid  = bvalid_q;
      bresp   = bresp_q;
   end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_regfile_slave
//
// Directed self-checking bench for axi4_lite_regfile_slave (default
// parameters: 32-bit address, 8 registers). Inputs change just after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_axi4_lite_regfile_slave;

   logic        aclk;
   logic        aresetn;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int passed;
   int total;

   axi4_lite_regfile_slave #(
      .ADDRESS_WIDTH (32),
      .REG_DATA_WIDTH(32),
      .NUM_REGS      (8)
   ) dut (
      .axi4_lite_aclk   (aclk),
      .axi4_lite_aresetn(aresetn),
      .awaddr (awaddr),
      .awvalid(awvalid),
      .awready(awready),
      .wdata  (wdata),
      .wstrb  (wstrb),
      .wvalid (wvalid),
      .wready (wready),
      .bresp  (bresp),
      .bvalid (bvalid),
      .bready (bready),
      .araddr (araddr),
      .arvalid(arvalid),
      .arready(arready),
      .rdata  (rdata),
      .rresp  (rresp),
      .rvalid (rvalid),
      .rready (rready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Hard stop in case something wedges outside the bounded loops
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Full write transaction with bready high. Call just after a rising edge.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output bit ok);
      bit aw_now, w_now, b_now;
      logic [1:0] resp_s;
      awaddr = addr; awvalid = 1'b1;
      wdata = data; wstrb = strb; wvalid = 1'b1;
      bready = 1'b1;
      ok = 1'b0; resp = 2'bxx;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         aw_now = awvalid && awready;
         w_now  = wvalid && wready;
         b_now  = bvalid && bready;
         resp_s = bresp;
         @(posedge aclk); #1;
         if (aw_now) awvalid = 1'b0;
         if (w_now) wvalid = 1'b0;
         if (b_now) begin
            ok = 1'b1;
            resp = resp_s;
            break;
         end
      end
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
   endtask

   // Full read transaction; lat counts cycles from arvalid to rvalid.
   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat, output bit ok);
      bit ar_now, r_now;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      ok = 1'b0; lat = -1; data = 'x; resp = 'x;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         ar_now = arvalid && arready;
         r_now  = rvalid && rready;
         if (r_now) begin
            data = rdata; resp = rresp; lat = i;
         end
         @(posedge aclk); #1;
         if (ar_now) arvalid = 1'b0;
         if (r_now) begin
            ok = 1'b1;
            break;
         end
      end
      arvalid = 1'b0; rready = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r; int lat; bit ok;
      aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      total++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'd0) begin
         $display("[TB] FAIL reset_outputs: got %h required 0",
                  {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata});
      end else passed++;
      aresetn = 1'b1;
      #1;
      total++;
      if ({awready, wready, arready} !== 3'b000) begin
         $display("[TB] FAIL readies_before_edge: got %b required 000", {awready, wready, arready});
      end else passed++;
      @(posedge aclk); #1;
      total++;
      if ({awready, wready, arready} !== 3'b111) begin
         $display("[TB] FAIL readies_after_edge: got %b required 111", {awready, wready, arready});
      end else passed++;
      axi_read(32'h10, d, r, lat, ok);
      total++;
      if (!ok || d !== 32'h0 || r !== 2'b00) begin
         $display("[TB] FAIL reset_reg_value: ok=%0d got %h/%b required 00000000/00", ok, d, r);
      end else passed++;
   endtask

   task automatic test_same_cycle_write();
      logic [31:0] d; logic [1:0] r; int lat; bit ok;
      awaddr = 32'h04; awvalid = 1'b1;
      wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
      bready = 1'b0;
      @(negedge aclk);
      total++;
      if ({awready, wready, bvalid} !== 3'b110) begin
         $display("[TB] FAIL sc_accept: got aw/w/b %b required 110", {awready, wready, bvalid});
      end else passed++;
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge aclk);
      total++;
      if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
         $display("[TB] FAIL sc_bvalid: got b/resp/aw/w %b required 10000",
                  {bvalid, bresp, awready, wready});
      end else passed++;
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
      @(negedge aclk);
      total++;
      if ({bvalid, awready, wready} !== 3'b011) begin
         $display("[TB] FAIL sc_b_done: got b/aw/w %b required 011", {bvalid, awready, wready});
      end else passed++;
      @(posedge aclk); #1;
      axi_read(32'h04, d, r, lat, ok);
      total++;
      if (!ok || d !== 32'hDEADBEEF || r !== 2'b00 || lat != 1) begin
         $display("[TB] FAIL sc_readback: ok=%0d got %h/%b lat %0d required deadbeef/00 lat 1",
                  ok, d, r, lat);
      end else passed++;
   endtask

   task automatic test_strobes();
      logic [31:0] d; logic [1:0] r1, r2, r; int lat; bit ok1, ok2, ok;
      axi_write(32'h08, 32'h11223344, 4'hF, r1, ok1);
      axi_write(32'h08, 32'hAABBCCDD, 4'h5, r2, ok2);
      total++;
      if (!ok1 || !ok2 || r1 !== 2'b00 || r2 !== 2'b00) begin
         $display("[TB] FAIL strb_bresp: ok=%0d%0d got %b %b required 00 00", ok1, ok2, r1, r2);
      end else passed++;
      axi_read(32'h08, d, r, lat, ok);
      total++;
      if (!ok || d !== 32'h11BB33DD || r !== 2'b00) begin
         $display("[TB] FAIL strb_readback: ok=%0d got %h/%b required 11bb33dd/00", ok, d, r);
      end else passed++;
   endtask

   task automatic test_w_before_aw();
      logic [31:0] d; logic [1:0] r; int lat; bit ok;
      wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
      @(negedge aclk);
      total++;
      if (wready !== 1'b1) begin
         $display("[TB] FAIL wfirst_accept: got wready %b required 1", wready);
      end else passed++;
      @(posedge aclk); #1;
      wvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge aclk);
         total++;
         if ({wready, bvalid} !== 2'b00) begin
            $display("[TB] FAIL wfirst_wait%0d: got wready/bvalid %b required 00", i, {wready, bvalid});
         end else passed++;
         @(posedge aclk); #1;
      end
      awaddr = 32'h0C; awvalid = 1'b1;
      @(negedge aclk);
      total++;
      if ({awready, bvalid} !== 2'b10) begin
         $display("[TB] FAIL wfirst_aw: got awready/bvalid %b required 10", {awready, bvalid});
      end else passed++;
      @(posedge aclk); #1;
      awvalid = 1'b0;
      @(negedge aclk);
      total++;
      if ({bvalid, bresp} !== 3'b100) begin
         $display("[TB] FAIL wfirst_bvalid: got bvalid/bresp %b required 100", {bvalid, bresp});
      end else passed++;
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
      axi_read(32'h0C, d, r, lat, ok);
      total++;
      if (!ok || d !== 32'h5 || r !== 2'b00) begin
         $display("[TB] FAIL wfirst_readback: ok=%0d got %h/%b required 00000005/00", ok, d, r);
      end else passed++;
   endtask

   task automatic test_read_write_same_edge();
      logic [31:0] d; logic [1:0] r; int lat; bit ok;
      awaddr = 32'h08; awvalid = 1'b1;
      wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
      araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
      @(negedge aclk);
      total++;
      if ({awready, wready, arready} !== 3'b111) begin
         $display("[TB] FAIL rw_accept: got aw/w/ar %b required 111", {awready, wready, arready});
      end else passed++;
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(negedge aclk);
      total++;
      if ({rvalid, bvalid} !== 2'b11 || rdata !== 32'h11BB33DD) begin
         $display("[TB] FAIL rw_pre_write: got r/b %b rdata %h required 11 11bb33dd",
                  {rvalid, bvalid}, rdata);
      end else passed++;
      rready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0; bready = 1'b0;
      axi_read(32'h08, d, r, lat, ok);
      total++;
      if (!ok || d !== 32'h0 || r !== 2'b00) begin
         $display("[TB] FAIL rw_post_write: ok=%0d got %h/%b required 00000000/00", ok, d, r);
      end else passed++;
   endtask

   task automatic test_invalid_addr();
      logic [31:0] d; logic [1:0] r, r1, r2; int lat; bit ok, ok1, ok2;
      axi_write(32'h20, 32'hFFFFFFFF, 4'hF, r1, ok1);
      axi_write(32'h06, 32'h12121212, 4'hF, r2, ok2);
      total++;
      if (!ok1 || !ok2 || r1 !== 2'b10 || r2 !== 2'b10) begin
         $display("[TB] FAIL inv_bresp: ok=%0d%0d got %b %b required 10 10", ok1, ok2, r1, r2);
      end else passed++;
      axi_read(32'h00, d, r, lat, ok);
      total++;
      if (!ok || d !== 32'h0 || r !== 2'b00) begin
         $display("[TB] FAIL inv_reg0_kept: ok=%0d got %h/%b required 00000000/00", ok, d, r);
      end else passed++;
      axi_read(32'h04, d, r, lat, ok);
      total++;
      if (!ok || d !== 32'hDEADBEEF || r !== 2'b00) begin
         $display("[TB] FAIL inv_reg1_kept: ok=%0d got %h/%b required deadbeef/00", ok, d, r);
      end else passed++;
      axi_read(32'h20, d, r, lat, ok);
      total++;
      if (!ok || d !== 32'h0 || r !== 2'b10) begin
         $display("[TB] FAIL inv_read_20: ok=%0d got %h/%b required 00000000/10", ok, d, r);
      end else passed++;
      axi_read(32'h24, d, r, lat, ok);
      total++;
      if (!ok || d !== 32'h0 || r !== 2'b10) begin
         $display("[TB] FAIL inv_read_24: ok=%0d got %h/%b required 00000000/10", ok, d, r);
      end else passed++;
   endtask

   task automatic test_bready_stall();
      logic [31:0] d, rd; logic [1:0] r, rr; int lat; bit ok, got, ar_now, r_now;
      awaddr = 32'h10; awvalid = 1'b1;
      wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
      @(negedge aclk);
      @(posedge aclk); #1;
      // A second write is offered and must be held off while B is stalled
      awaddr = 32'h14; wdata = 32'h99999999;
      araddr = 32'h04; arvalid = 1'b1; rready = 1'b1;
      got = 1'b0; rd = 'x; rr = 'x;
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         total++;
         if ({bvalid, awready, wready} !== 3'b100) begin
            $display("[TB] FAIL stall_cycle%0d: got b/aw/w %b required 100", i, {bvalid, awready, wready});
         end else passed++;
         ar_now = arvalid && arready;
         r_now  = rvalid && rready;
         if (r_now) begin
            got = 1'b1; rd = rdata; rr = rresp;
         end
         @(posedge aclk); #1;
         if (ar_now) arvalid = 1'b0;
         if (r_now) rready = 1'b0;
      end
      arvalid = 1'b0; rready = 1'b0;
      total++;
      if (!got || rd !== 32'hDEADBEEF || rr !== 2'b00) begin
         $display("[TB] FAIL stall_read: got=%0d %h/%b required deadbeef/00", got, rd, rr);
      end else passed++;
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
      @(negedge aclk);
      total++;
      if ({bvalid, bresp} !== 3'b100) begin
         $display("[TB] FAIL stall_bresp: got bvalid/bresp %b required 100", {bvalid, bresp});
      end else passed++;
      @(posedge aclk); #1;
      bready = 1'b0;
      axi_read(32'h10, d, r, lat, ok);
      total++;
      if (!ok || d !== 32'h12345678 || r !== 2'b00) begin
         $display("[TB] FAIL stall_reg10: ok=%0d got %h/%b required 12345678/00", ok, d, r);
      end else passed++;
      axi_read(32'h14, d, r, lat, ok);
      total++;
      if (!ok || d !== 32'h0 || r !== 2'b00) begin
         $display("[TB] FAIL stall_reg14_blocked: ok=%0d got %h/%b required 00000000/00", ok, d, r);
      end else passed++;
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] d; logic [1:0] r; int lat; bit ok;
      awaddr = 32'h18; awvalid = 1'b1;
      wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
      araddr = 32'h04; arvalid = 1'b1; rready = 1'b0;
      @(negedge aclk);
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(negedge aclk);
      total++;
      if ({bvalid, rvalid} !== 2'b11) begin
         $display("[TB] FAIL mid_both_valid: got b/r %b required 11", {bvalid, rvalid});
      end else passed++;
      aresetn = 1'b0;
      #1;
      total++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'd0) begin
         $display("[TB] FAIL mid_reset_outputs: got %h required 0",
                  {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata});
      end else passed++;
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk); #1;
      for (int i = 0; i < 8; i++) begin
         axi_read(32'(i * 4), d, r, lat, ok);
         total++;
         if (!ok || d !== 32'h0 || r !== 2'b00) begin
            $display("[TB] FAIL mid_reg%0d_cleared: ok=%0d got %h/%b required 00000000/00", i, ok, d, r);
         end else passed++;
      end
   endtask

   initial begin
      passed  = 0;
      total   = 0;
      aresetn = 1'b0;
      awaddr = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0;
      araddr = '0; arvalid = 1'b0;
      rready = 1'b0;

      test_reset();
      test_same_cycle_write();
      test_strobes();
      test_w_before_aw();
      test_read_write_same_edge();
      test_invalid_addr();
      test_bready_stall();
      test_reset_mid_op();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
